// File: rtl/bna_pkg.sv
// bna_pkg -- shared definitions for the activation pack path.
//
// Contents:
//   BNA_LANES         number of activation lanes packed into one buffer word
//   BNA_LANE_IDX_W    width of a lane index (log2 of BNA_LANES)
//   pack_state_t      state encoding of the activation pack writer FSM
//   bna_is_last_lane  helper: true when a lane index addresses the top lane
package bna_pkg;

    localparam int BNA_LANES      = 4;
    localparam int BNA_LANE_IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_DONE = 2'd2
    } pack_state_t;

    function automatic logic bna_is_last_lane(input logic [BNA_LANE_IDX_W-1:0] lane);
        return lane == BNA_LANE_IDX_W'(BNA_LANES - 1);
    endfunction

endpackage

// File: rtl/activation_pack_writer.sv
// activation_pack_writer -- packs a stream of activation beats into 4-lane
// words and writes them to consecutive activation buffer addresses.
//
// A frame begins with start_i in IDLE, which latches base_addr_i. Each accepted
// beat fills the next lane (lane 0 in the low bits). A word is written when
// lane 3 fills or when the beat carrying act_last_i is accepted; any lanes not
// reached are zero. The write strobe, address and data appear one cycle after
// the emitting beat. done_o pulses together with the final write of a frame.
//
// Parameters:
//   DATA_WIDTH         bits per activation lane
//   BUFFER_ADDR_WIDTH  activation buffer address bits
//
// Ports:
//   clk               clock, rising edge
//   rst               synchronous active-high reset
//   start_i           frame start pulse (honoured in IDLE only)
//   base_addr_i       first write address of the frame
//   act_valid_i       activation beat valid
//   act_data_i        activation value
//   act_last_i        final beat of the frame (qualified by act_valid_i)
//   act_ready_o       beat accepted when act_valid_i && act_ready_o
//   buffer_wr_en_o    one-cycle buffer write strobe
//   buffer_wr_addr_o  buffer write address (held between writes)
//   buffer_data_o     packed 4-lane word (held between writes)
//   done_o            one-cycle frame-complete pulse
//   word_count_o      (only with ACT_PACK_WORD_COUNT_EN) saturating count of
//                     words written since the last accepted start
//
// Optional feature macro: ACT_PACK_WORD_COUNT_EN
module activation_pack_writer
    import bna_pkg::*;
#(
    parameter int DATA_WIDTH        = 7,
    parameter int BUFFER_ADDR_WIDTH = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic [BUFFER_ADDR_WIDTH-1:0]    base_addr_i,
    input  logic                            act_valid_i,
    input  logic [DATA_WIDTH-1:0]           act_data_i,
    input  logic                            act_last_i,
    output logic                            act_ready_o,
    output logic                            buffer_wr_en_o,
    output logic [BUFFER_ADDR_WIDTH-1:0]    buffer_wr_addr_o,
    output logic [DATA_WIDTH*BNA_LANES-1:0] buffer_data_o,
    output logic                            done_o
`ifdef ACT_PACK_WORD_COUNT_EN
    ,
    output logic [BUFFER_ADDR_WIDTH:0]      word_count_o
`endif
);

    localparam int WORD_WIDTH = DATA_WIDTH * BNA_LANES;

    pack_state_t                    state_reg;
    pack_state_t                    state_next;
    logic                           ready_reg;
    logic [BNA_LANE_IDX_W-1:0]      lane_reg;
    logic [BNA_LANE_IDX_W-1:0]      lane_next;
    logic [WORD_WIDTH-1:0]          acc_reg;
    logic [WORD_WIDTH-1:0]          acc_next;
    logic [WORD_WIDTH-1:0]          word_next;
    logic [BUFFER_ADDR_WIDTH-1:0]   ptr_reg;
    logic                           wr_en_reg;
    logic [BUFFER_ADDR_WIDTH-1:0]   wr_addr_reg;
    logic [WORD_WIDTH-1:0]          wr_data_reg;
    logic                           done_reg;

    logic start_accept;
    logic beat_accept;
    logic emit;

    // ready_reg is high exactly while in PACK, so it also gates beats that
    // arrive in any other state.
    assign start_accept = (state_reg == ST_IDLE) && start_i;
    assign beat_accept  = act_valid_i && ready_reg;
    assign emit         = beat_accept && (bna_is_last_lane(lane_reg) || act_last_i);

    // Merge the incoming beat into its lane. The accumulator is cleared at
    // every word boundary, so lanes above the current one are already zero
    // when a short final word is emitted.
    for (genvar gi = 0; gi < BNA_LANES; gi++) begin : g_lane
        assign word_next[gi*DATA_WIDTH +: DATA_WIDTH] =
            (lane_reg == BNA_LANE_IDX_W'(gi)) ? act_data_i
                                               : acc_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start_i)                   state_next = ST_PACK;
            ST_PACK: if (beat_accept && act_last_i) state_next = ST_DONE;
            ST_DONE:                                state_next = ST_IDLE;
            default:                                state_next = ST_IDLE;
        endcase
    end

    // Lane counter and partial-word accumulator.
    always_comb begin
        lane_next = lane_reg;
        acc_next  = acc_reg;
        if (start_accept || emit) begin
            lane_next = '0;
            acc_next  = '0;
        end else if (beat_accept) begin
            lane_next = lane_reg + 1'b1;
            acc_next  = word_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            ready_reg   <= 1'b0;
            lane_reg    <= '0;
            acc_reg     <= '0;
            ptr_reg     <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == ST_PACK);
            lane_reg  <= lane_next;
            acc_reg   <= acc_next;
            wr_en_reg <= emit;
            done_reg  <= emit && act_last_i;

            // Address and data only move on a write, so they stay stable
            // while the strobe is low. The pointer wraps naturally.
            if (emit) begin
                wr_addr_reg <= ptr_reg;
                wr_data_reg <= word_next;
            end

            if (start_accept) begin
                ptr_reg <= base_addr_i;
            end else if (emit) begin
                ptr_reg <= ptr_reg + 1'b1;
            end
        end
    end

    assign act_ready_o      = ready_reg;
    assign buffer_wr_en_o   = wr_en_reg;
    assign buffer_wr_addr_o = wr_addr_reg;
    assign buffer_data_o    = wr_data_reg;
    assign done_o           = done_reg;

`ifdef ACT_PACK_WORD_COUNT_EN
    logic [BUFFER_ADDR_WIDTH:0] count_reg;

    // Counts alongside the write strobe and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (start_accept) begin
            count_reg <= '0;
        end else if (emit && (count_reg != '1)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign word_count_o = count_reg;
`endif

endmodule

// File: tb/tb_activation_pack_writer.sv
// tb_activation_pack_writer -- directed self-checking bench for
// activation_pack_writer (DATA_WIDTH=7, BUFFER_ADDR_WIDTH=15).
// Build with ACT_PACK_WORD_COUNT_EN defined to also check word_count_o.
module tb_activation_pack_writer;

    localparam int DW = 7;
    localparam int AW = 15;
    localparam int WW = DW * 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic          act_valid_i;
    logic [DW-1:0] act_data_i;
    logic          act_last_i;
    logic          act_ready_o;
    logic          buffer_wr_en_o;
    logic [AW-1:0] buffer_wr_addr_o;
    logic [WW-1:0] buffer_data_o;
    logic          done_o;
`ifdef ACT_PACK_WORD_COUNT_EN
    logic [AW:0]   word_count_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    activation_pack_writer #(
        .DATA_WIDTH        (DW),
        .BUFFER_ADDR_WIDTH (AW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .base_addr_i      (base_addr_i),
        .act_valid_i      (act_valid_i),
        .act_data_i       (act_data_i),
        .act_last_i       (act_last_i),
        .act_ready_o      (act_ready_o),
        .buffer_wr_en_o   (buffer_wr_en_o),
        .buffer_wr_addr_o (buffer_wr_addr_o),
        .buffer_data_o    (buffer_data_o),
        .done_o           (done_o)
`ifdef ACT_PACK_WORD_COUNT_EN
        ,
        .word_count_o     (word_count_o)
`endif
    );

    // Write log, sampled on the falling edge.
    logic [AW-1:0] wa_q[$];
    logic [WW-1:0] wd_q[$];
    logic          wdn_q[$];
    int            stray_done;

    always @(negedge clk) begin
        if (buffer_wr_en_o === 1'b1) begin
            wa_q.push_back(buffer_wr_addr_o);
            wd_q.push_back(buffer_data_o);
            wdn_q.push_back(done_o);
        end else if (done_o === 1'b1) begin
            stray_done++;
        end
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wdn_q.delete();
        stray_done = 0;
    endtask

    // Stimulus: start a frame at base, then n beats of first, first+1, ...
    task automatic run_frame(input logic [AW-1:0] base, input int n, input int first);
        @(posedge clk); #1;
        start_i     = 1'b1;
        base_addr_i = base;
        @(posedge clk); #1;
        start_i     = 1'b0;
        base_addr_i = '0;
        n_checks++;
        if (act_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_start: got %b, want 1", act_ready_o);
        end
        for (int i = 0; i < n; i++) begin
            act_valid_i = 1'b1;
            act_data_i  = DW'(first + i);
            act_last_i  = (i == n - 1);
            @(posedge clk); #1;
        end
        act_valid_i = 1'b0;
        act_last_i  = 1'b0;
        act_data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({act_ready_o, buffer_wr_en_o, done_o} !== 3'b000 ||
            buffer_wr_addr_o !== '0 || buffer_data_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b we=%b done=%b addr=%h data=%h, want all 0",
                     act_ready_o, buffer_wr_en_o, done_o, buffer_wr_addr_o, buffer_data_o);
        end
`ifdef ACT_PACK_WORD_COUNT_EN
        n_checks++;
        if (word_count_o !== '0) begin
            n_fail++;
            $display("FAIL reset_word_count: got %0d, want 0", word_count_o);
        end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_two_words();
        logic [AW-1:0] ea[2];
        logic [WW-1:0] ed[2];
        logic          edn[2];
        ea  = '{15'h0010, 15'h0011};
        ed  = '{{7'd4, 7'd3, 7'd2, 7'd1}, {7'd8, 7'd7, 7'd6, 7'd5}};
        edn = '{1'b0, 1'b1};
        clear_log();
        run_frame(15'h0010, 8, 1);
        n_checks++;
        if (wa_q.size() != 2) begin
            n_fail++;
            $display("FAIL two_words_count: got %0d writes, want 2", wa_q.size());
        end
        for (int i = 0; i < 2 && i < wa_q.size(); i++) begin
            n_checks++;
            if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i] || wdn_q[i] !== edn[i]) begin
                n_fail++;
                $display("FAIL two_words_w%0d: got addr=%h data=%h done=%b, want addr=%h data=%h done=%b",
                         i, wa_q[i], wd_q[i], wdn_q[i], ea[i], ed[i], edn[i]);
            end
        end
        n_checks++;
        if (stray_done != 0) begin
            n_fail++;
            $display("FAIL two_words_stray_done: got %0d, want 0", stray_done);
        end
        n_checks++;
        if (buffer_wr_en_o !== 1'b0 || buffer_wr_addr_o !== ea[1] || buffer_data_o !== ed[1]) begin
            n_fail++;
            $display("FAIL two_words_hold: got we=%b addr=%h data=%h, want we=0 addr=%h data=%h",
                     buffer_wr_en_o, buffer_wr_addr_o, buffer_data_o, ea[1], ed[1]);
        end
    endtask

    task automatic test_partial_word();
        logic [AW-1:0] ea[2];
        logic [WW-1:0] ed[2];
        logic          edn[2];
        ea  = '{15'h0100, 15'h0101};
        ed  = '{{7'd4, 7'd3, 7'd2, 7'd1}, {7'd0, 7'd0, 7'd6, 7'd5}};
        edn = '{1'b0, 1'b1};
        clear_log();
        run_frame(15'h0100, 6, 1);
        n_checks++;
        if (wa_q.size() != 2) begin
            n_fail++;
            $display("FAIL partial_count: got %0d writes, want 2", wa_q.size());
        end
        for (int i = 0; i < 2 && i < wa_q.size(); i++) begin
            n_checks++;
            if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i] || wdn_q[i] !== edn[i]) begin
                n_fail++;
                $display("FAIL partial_w%0d: got addr=%h data=%h done=%b, want addr=%h data=%h done=%b",
                         i, wa_q[i], wd_q[i], wdn_q[i], ea[i], ed[i], edn[i]);
            end
        end
    endtask

    task automatic test_addr_wrap();
        logic [AW-1:0] ea[2];
        logic [WW-1:0] ed[2];
        ea = '{15'h7FFF, 15'h0000};
        ed = '{{7'd4, 7'd3, 7'd2, 7'd1}, {7'd8, 7'd7, 7'd6, 7'd5}};
        clear_log();
        run_frame(15'h7FFF, 8, 1);
        n_checks++;
        if (wa_q.size() != 2) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d writes, want 2", wa_q.size());
        end
        for (int i = 0; i < 2 && i < wa_q.size(); i++) begin
            n_checks++;
            if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
                n_fail++;
                $display("FAIL wrap_w%0d: got addr=%h data=%h, want addr=%h data=%h",
                         i, wa_q[i], wd_q[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        clear_log();
        @(posedge clk); #1;
        start_i     = 1'b1;
        base_addr_i = 15'h0050;
        @(posedge clk); #1;
        start_i     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            act_valid_i = 1'b1;
            act_data_i  = DW'(i + 1);
            act_last_i  = 1'b0;
            @(posedge clk); #1;
        end
        act_valid_i = 1'b0;
        rst         = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({act_ready_o, buffer_wr_en_o, done_o} !== 3'b000 ||
            buffer_wr_addr_o !== '0 || buffer_data_o !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got rdy=%b we=%b done=%b addr=%h data=%h, want all 0",
                     act_ready_o, buffer_wr_en_o, done_o, buffer_wr_addr_o, buffer_data_o);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (wa_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_no_write: got %0d writes, want 0", wa_q.size());
        end
        clear_log();
        run_frame(15'h0020, 4, 9);
        n_checks++;
        if (wa_q.size() != 1) begin
            n_fail++;
            $display("FAIL midreset_restart_count: got %0d writes, want 1", wa_q.size());
        end else if (wa_q[0] !== 15'h0020 || wd_q[0] !== {7'd12, 7'd11, 7'd10, 7'd9} || wdn_q[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_restart: got addr=%h data=%h done=%b, want addr=0020 data=%h done=1",
                     wa_q[0], wd_q[0], wdn_q[0], {7'd12, 7'd11, 7'd10, 7'd9});
        end
    endtask

    task automatic test_ignored_inputs();
        clear_log();
        // Beats in IDLE must be ignored.
        for (int i = 0; i < 3; i++) begin
            act_valid_i = 1'b1;
            act_data_i  = 7'h33;
            act_last_i  = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if (act_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_ready_c%0d: got %b, want 0", i, act_ready_o);
            end
        end
        act_valid_i = 1'b0;
        act_last_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (wa_q.size() != 0 || stray_done != 0) begin
            n_fail++;
            $display("FAIL idle_beats: got %0d writes %0d done, want 0 and 0", wa_q.size(), stray_done);
        end
        // start_i pulsed mid-frame with a different base must be ignored.
        @(posedge clk); #1;
        start_i     = 1'b1;
        base_addr_i = 15'h0030;
        @(posedge clk); #1;
        start_i     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            act_valid_i = 1'b1;
            act_data_i  = DW'(i + 1);
            act_last_i  = (i == 3);
            start_i     = (i == 1);
            base_addr_i = (i == 1) ? 15'h0055 : 15'h0000;
            @(posedge clk); #1;
        end
        act_valid_i = 1'b0;
        act_last_i  = 1'b0;
        start_i     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (wa_q.size() != 1) begin
            n_fail++;
            $display("FAIL pack_start_count: got %0d writes, want 1", wa_q.size());
        end else if (wa_q[0] !== 15'h0030 || wd_q[0] !== {7'd4, 7'd3, 7'd2, 7'd1} || wdn_q[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pack_start_word: got addr=%h data=%h done=%b, want addr=0030 data=%h done=1",
                     wa_q[0], wd_q[0], wdn_q[0], {7'd4, 7'd3, 7'd2, 7'd1});
        end
        n_checks++;
        if (act_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_idle_ready: got %b, want 0", act_ready_o);
        end
    endtask

    task automatic test_single_beat();
        clear_log();
        run_frame(15'h0040, 1, 5);
        n_checks++;
        if (wa_q.size() != 1) begin
            n_fail++;
            $display("FAIL single_count: got %0d writes, want 1", wa_q.size());
        end else if (wa_q[0] !== 15'h0040 || wd_q[0] !== {7'd0, 7'd0, 7'd0, 7'd5} || wdn_q[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_word: got addr=%h data=%h done=%b, want addr=0040 data=%h done=1",
                     wa_q[0], wd_q[0], wdn_q[0], {7'd0, 7'd0, 7'd0, 7'd5});
        end
`ifdef ACT_PACK_WORD_COUNT_EN
        n_checks++;
        if (word_count_o !== 16'd1) begin
            n_fail++;
            $display("FAIL single_word_count: got %0d, want 1", word_count_o);
        end
`endif
    endtask

    task automatic test_word_count();
        clear_log();
        run_frame(15'h0060, 12, 1);
        n_checks++;
        if (wa_q.size() != 3) begin
            n_fail++;
            $display("FAIL wc_writes: got %0d writes, want 3", wa_q.size());
        end else if (wa_q[2] !== 15'h0062 || wd_q[2] !== {7'd12, 7'd11, 7'd10, 7'd9} || wdn_q[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL wc_last_word: got addr=%h data=%h done=%b, want addr=0062 data=%h done=1",
                     wa_q[2], wd_q[2], wdn_q[2], {7'd12, 7'd11, 7'd10, 7'd9});
        end
`ifdef ACT_PACK_WORD_COUNT_EN
        n_checks++;
        if (word_count_o !== 16'd3) begin
            n_fail++;
            $display("FAIL wc_value: got %0d, want 3", word_count_o);
        end
`endif
    endtask

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        base_addr_i = '0;
        act_valid_i = 1'b0;
        act_data_i  = '0;
        act_last_i  = 1'b0;
        stray_done  = 0;
        test_reset();
        test_two_words();
        test_partial_word();
        test_addr_wrap();
        test_mid_frame_reset();
        test_ignored_inputs();
        test_word_count();
        test_single_beat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
